// File: rtl/sdram_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-SDRAM bridge.
//   state_t      : transaction FSM states
//   SD_ADDR_PAD  : zero pad above the word address in the controller byte address
//   sd_byte_addr : forms the 25-bit controller byte address from a word address
package sdram_bridge_pkg;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    ACK  = 3'd4
  } state_t;

  localparam int WB_ADR_W = 21;
  localparam int SD_ADDR_W = 25;
  localparam int DAT_W = 16;
  localparam logic [2:0] SD_ADDR_PAD = 3'b000;

  // Word address -> byte address; bit 0 is always zero for 16-bit words.
  function automatic logic [SD_ADDR_W-1:0] sd_byte_addr(input logic [WB_ADR_W-1:0] adr);
    return {SD_ADDR_PAD, adr, 1'b0};
  endfunction

endpackage

// File: rtl/sdram_init_seq.sv
// Controller init sequencing for the SDRAM bridge.
//   clk_p, rst_n  : clock, async active-low reset
//   sdram_reset   : async re-init request (synchronised here)
//   sd_ready      : controller idle
//   init_rst      : synchronised re-init request, forces the bridge FSM to INIT
//   sd_init       : init request to the controller
//   sdram_ready   : sticky "controller initialised" flag
// INIT_DELAY must be >= 1.
import sdram_bridge_pkg::*;

module sdram_init_seq #(
  parameter int INIT_DELAY  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_p,
  input  logic rst_n,
  input  logic sdram_reset,
  input  logic sd_ready,
  output logic init_rst,
  output logic sd_init,
  output logic sdram_ready
);

  localparam int CW = (INIT_DELAY < 2) ? 1 : $clog2(INIT_DELAY);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;

  assign init_rst = sync_q[SYNC_STAGES-1];

  // The chain resets to all ones so rst_n release behaves exactly like a
  // sdram_reset release: the delay count only starts once the chain flushes.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      cnt         <= '0;
      sd_init     <= 1'b1;
      sdram_ready <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(sdram_reset);
      if (init_rst) begin
        cnt         <= '0;
        sd_init     <= 1'b1;
        sdram_ready <= 1'b0;
      end else begin
        if (sd_init) begin
          if (cnt == CW'(INIT_DELAY - 1)) sd_init <= 1'b0;
          else                            cnt     <= cnt + 1'b1;
        end
        if (sd_ready && !sd_init) sdram_ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_wb_bridge.sv
// Wishbone-style 16-bit slave -> SDRAM controller rd/we level requests.
// Ports:
//   clk_p, rst_n                      : clock, async active-low reset
//   sdram_reset                       : async re-init request
//   wb_stb/we/sel/adr/dat_i           : kernel request, stb held until wb_ack
//   wb_dat_o, wb_ack                  : read data / completion
//   sdram_ready, timeout_err          : sticky status flags
//   sd_init/we/rd/wtbt/addr/din       : controller request side
//   sd_dout, sd_ready                 : controller response side
// Optional: define SDRAM_BRIDGE_TIMEOUT_EN to bound REQ+WAIT to TIMEOUT
// cycles (forced completion, reads return 0, timeout_err set). Without it
// timeout_err is tied low and REQ/WAIT wait indefinitely.
import sdram_bridge_pkg::*;

module sdram_wb_bridge #(
  parameter int INIT_DELAY  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic        clk_p,
  input  logic        rst_n,
  input  logic        sdram_reset,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [1:0]  wb_sel,
  input  logic [21:1] wb_adr,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack,
  output logic        sdram_ready,
  output logic        timeout_err,
  output logic        sd_init,
  output logic        sd_we,
  output logic        sd_rd,
  output logic [1:0]  sd_wtbt,
  output logic [24:0] sd_addr,
  output logic [15:0] sd_din,
  input  logic [15:0] sd_dout,
  input  logic        sd_ready
);

  state_t state;
  logic   init_rst;
  logic   req_we;
  logic   aborted;   // wb_stb dropped while the SDRAM cycle was in flight
  logic   busy;
  logic   to_hit;
  state_t done_st;

  sdram_init_seq #(
    .INIT_DELAY (INIT_DELAY),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_init (
    .clk_p      (clk_p),
    .rst_n      (rst_n),
    .sdram_reset(sdram_reset),
    .sd_ready   (sd_ready),
    .init_rst   (init_rst),
    .sd_init    (sd_init),
    .sdram_ready(sdram_ready)
  );

  assign busy    = (state == REQ) || (state == WAIT);
  assign wb_ack  = (state == ACK) && wb_stb;
  // An abandoned transaction completes silently so a fresh stb is never
  // acked with stale data.
  assign done_st = (aborted || !wb_stb) ? IDLE : ACK;

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  assign to_hit = busy && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (init_rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt <= busy ? to_cnt + 1'b1 : '0;
      if (to_hit) timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign to_hit         = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      sd_we    <= 1'b0;
      sd_rd    <= 1'b0;
      sd_wtbt  <= '0;
      sd_addr  <= '0;
      sd_din   <= '0;
      wb_dat_o <= '0;
      req_we   <= 1'b0;
      aborted  <= 1'b0;
    end else if (init_rst) begin
      state   <= INIT;
      sd_we   <= 1'b0;
      sd_rd   <= 1'b0;
      aborted <= 1'b0;
    end else begin
      if (busy && !wb_stb) aborted <= 1'b1;
      case (state)
        INIT: if (!sd_init) state <= IDLE;
        IDLE: begin
          aborted <= 1'b0;
          if (wb_stb && sdram_ready && sd_ready) begin
            sd_addr <= sd_byte_addr(wb_adr);
            sd_din  <= wb_dat_i;
            sd_wtbt <= wb_we ? wb_sel : 2'b11;
            req_we  <= wb_we;
            if (wb_we && (wb_sel == 2'b00)) begin
              state <= ACK;  // nothing to write: complete without an SDRAM cycle
            end else begin
              sd_we <= wb_we;
              sd_rd <= !wb_we;
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (to_hit) begin
            sd_we <= 1'b0;
            sd_rd <= 1'b0;
            if (!req_we) wb_dat_o <= '0;
            state <= done_st;
          end else if (!sd_ready) begin
            sd_we <= 1'b0;
            sd_rd <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (to_hit) begin
            if (!req_we) wb_dat_o <= '0;
            state <= done_st;
          end else if (sd_ready) begin
            if (!req_we) wb_dat_o <= sd_dout;
            state <= done_st;
          end
        end
        ACK: if (!wb_stb) state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Self-checking bench for sdram_wb_bridge (default build, no timeout).
module tb_sdram_wb_bridge;

  logic        clk_p = 1'b0;
  logic        rst_n = 1'b1;
  logic        sdram_reset = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [1:0]  wb_sel = 2'b00;
  logic [21:1] wb_adr = '0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic        wb_ack, sdram_ready, timeout_err, sd_init, sd_we, sd_rd;
  logic [1:0]  sd_wtbt;
  logic [24:0] sd_addr;
  logic [15:0] sd_din;
  logic [15:0] sd_dout = '0;
  logic        sd_ready = 1'b1;

  int tests = 0;
  int errs  = 0;

  typedef struct {
    logic        rd;
    logic [15:0] dat;
  } exp_t;
  exp_t sb[$];

  sdram_wb_bridge dut (
    .clk_p(clk_p), .rst_n(rst_n), .sdram_reset(sdram_reset),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .sdram_ready(sdram_ready), .timeout_err(timeout_err), .sd_init(sd_init),
    .sd_we(sd_we), .sd_rd(sd_rd), .sd_wtbt(sd_wtbt), .sd_addr(sd_addr),
    .sd_din(sd_din), .sd_dout(sd_dout), .sd_ready(sd_ready)
  );

  always #5 clk_p = ~clk_p;

  // Controller model: accepts a request by dropping sd_ready, returns
  // rd_data with sd_ready six cycles later.
  logic [15:0] rd_data = 16'h0000;
  int busy = 0;
  always @(posedge clk_p) begin
    if (busy == 0) begin
      if (sd_rd || sd_we) begin
        sd_ready <= 1'b0;
        busy     <= 6;
      end
    end else begin
      busy <= busy - 1;
      if (busy == 1) begin
        sd_ready <= 1'b1;
        sd_dout  <= rd_data;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One full transaction; the expected response goes into the scoreboard
  // when stimulus is driven and is popped on wb_ack.
  task automatic txn(input logic we, input logic [1:0] sel, input logic [21:1] adr,
                     input logic [15:0] dat, input logic [15:0] rdat,
                     input logic [24:0] exp_addr);
    exp_t e;
    int n;
    logic seen;
    logic [24:0] a;
    logic [1:0]  wt;
    logic [15:0] din;
    logic nop;
    nop = we && (sel == 2'b00);
    seen = 1'b0; a = '0; wt = '0; din = '0;
    rd_data = rdat;
    e.rd = !we; e.dat = rdat;
    sb.push_back(e);
    @(negedge clk_p);
    wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat_i = dat;
    @(negedge clk_p);
    chk("issue_lat", {sd_we, sd_rd}, nop ? 2'b00 : (we ? 2'b10 : 2'b01));
    n = 0;
    while (n < 100) begin
      if (sd_we || sd_rd) begin
        seen = 1'b1; a = sd_addr; wt = sd_wtbt; din = sd_din;
      end
      if (wb_ack) break;
      @(negedge clk_p);
      n++;
    end
    chk("ack_wait", wb_ack, 1'b1);
    if (wb_ack && sb.size() > 0) begin
      e = sb.pop_front();
      if (e.rd) chk("rdata", wb_dat_o, e.dat);
    end
    chk("req_seen", seen, !nop);
    if (seen) begin
      chk("sd_addr", a, exp_addr);
      chk("sd_wtbt", wt, we ? sel : 2'b11);
      if (we) chk("sd_din", din, dat);
    end
    wb_stb = 1'b0;
    #1 chk("ack_fall", wb_ack, 1'b0);
    @(negedge clk_p);
    chk("ack_once", wb_ack, 1'b0);
  endtask

  // Counts negedges from now until sd_init drops; acks seen meanwhile are returned.
  task automatic init_len(output int n, output int acks);
    n = 0; acks = 0;
    while (n < 50) begin
      @(negedge clk_p);
      n++;
      if (wb_ack) acks++;
      if (!sd_init) break;
    end
  endtask

  initial begin
    int n, acks;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk_p);
    chk("rst_sd_init", sd_init, 1'b1);
    chk("rst_ready", sdram_ready, 1'b0);
    chk("rst_ack", wb_ack, 1'b0);
    chk("rst_req", {sd_we, sd_rd}, 2'b00);
    chk("rst_addr", sd_addr, 25'h0);
    chk("rst_dat_o", wb_dat_o, 16'h0);
    chk("rst_tmo", timeout_err, 1'b0);

    rst_n = 1'b1;
    init_len(n, acks);
    chk("init_len", n, 5);
    chk("ready_early", sdram_ready, 1'b0);
    @(negedge clk_p);
    chk("ready_set", sdram_ready, 1'b1);

    // Read, write with mask, empty write, top of address range
    txn(1'b0, 2'b11, 21'h000123, 16'h0000, 16'hBEEF, 25'h0000246);
    txn(1'b1, 2'b10, 21'h000040, 16'hA55A, 16'h0000, 25'h0000080);
    txn(1'b1, 2'b00, 21'h000041, 16'h1111, 16'h0000, 25'h0000082);
    txn(1'b1, 2'b01, 21'h1FFFFF, 16'h5AA5, 16'h0000, 25'h03FFFFE);
    txn(1'b0, 2'b01, 21'h1FFFFF, 16'h0000, 16'h7E81, 25'h03FFFFE);

    // Abort: drop stb once the request was accepted (FSM in WAIT)
    rd_data = 16'hDEAD;
    @(negedge clk_p);
    wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b11; wb_adr = 21'h000005;
    n = 0;
    while (!sd_rd && n < 20) begin @(negedge clk_p); n++; end
    while (sd_rd && n < 20) begin @(negedge clk_p); n++; end
    chk("abort_reach", n < 20, 1'b1);
    wb_stb = 1'b0;
    acks = 0;
    repeat (12) begin @(negedge clk_p); if (wb_ack) acks++; end
    chk("abort_noack", acks, 0);
    txn(1'b0, 2'b11, 21'h000007, 16'h0000, 16'h1234, 25'h000000E);

    // Re-init in the middle of a read
    rd_data = 16'hCAFE;
    @(negedge clk_p);
    wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b11; wb_adr = 21'h000009;
    n = 0;
    while (!sd_rd && n < 20) begin @(negedge clk_p); n++; end
    chk("reinit_req", sd_rd, 1'b1);
    sdram_reset = 1'b1;
    n = 0; acks = 0;
    while (!sd_init && n < 20) begin
      @(negedge clk_p); n++;
      if (wb_ack) acks++;
    end
    chk("reinit_init", sd_init, 1'b1);
    chk("reinit_rd", sd_rd, 1'b0);
    chk("reinit_ready", sdram_ready, 1'b0);
    wb_stb = 1'b0;
    @(negedge clk_p);
    sdram_reset = 1'b0;
    init_len(n, acks);
    chk("reinit_len", n, 5);
    chk("reinit_noack", acks, 0);
    @(negedge clk_p);
    chk("reinit_ready_set", sdram_ready, 1'b1);
    txn(1'b0, 2'b11, 21'h0ABCDE, 16'h0000, 16'h0F0F, 25'h01579BC);

    chk("sb_empty", sb.size(), 0);
    chk("tmo_flag", timeout_err, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got stuck want finish");
    $fatal(1, "watchdog");
  end

endmodule
